// File: rtl/mag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mag_pkg : shared types and defaults for the magnetron controller     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package mag_pkg;

  localparam int MAG_MAX_SECS = 99;
  localparam int MAG_TIME_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mag_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mag_timer : saturating seconds countdown with load, clear and zero   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module mag_timer
  import mag_pkg::*;
#(
  parameter int MAX_SECS = MAG_MAX_SECS,
  parameter int TIME_W   = MAG_TIME_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              clr,
  input  logic              dec,
  output logic [TIME_W-1:0] count,
  output logic              zero
);

  localparam logic [TIME_W-1:0] c_max = TIME_W'(MAX_SECS);

  logic [TIME_W-1:0] r_count;

  // Clear wins over load; a decrement at zero holds rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= (load_val > c_max) ? c_max : load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - TIME_W'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mag_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mag_ctrl : microwave cook FSM driving the magnetron SR latch pulses  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module mag_ctrl
  import mag_pkg::*;
#(
  parameter int MAX_SECS = MAG_MAX_SECS,
  parameter int TIME_W   = MAG_TIME_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              load_en,
  input  logic [TIME_W-1:0] load_secs,
  input  logic              start,
  input  logic              stop,
  input  logic              door_closed,
  output logic              set,
  output logic              reset,
  output logic              cooking,
  output logic [TIME_W-1:0] remaining,
  output logic              done
);

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              w_clr;
  logic              w_dec;
  logic              w_done;
  logic              w_zero;
  logic [TIME_W-1:0] w_remaining;
  logic              r_set;
  logic              r_reset;
  logic              r_cooking;
  logic              r_done;

  mag_timer #(
    .MAX_SECS (MAX_SECS),
    .TIME_W   (TIME_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (load_secs),
    .clr      (w_clr),
    .dec      (w_dec),
    .count    (w_remaining),
    .zero     (w_zero)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_clr  = 1'b0;
    w_dec  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A load in the same cycle as start takes precedence.
        if (load_en) begin
          w_load = 1'b1;
        end else if (start && door_closed && !w_zero) begin
          w_next = ST_COOK;
        end
      end
      ST_COOK: begin
        if (!door_closed || stop) begin
          w_next = ST_PAUSE;
        end else if (tick_1hz) begin
          w_dec = 1'b1;
          if (w_remaining == TIME_W'(1)) begin
            w_next = ST_DONE;
            w_done = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_next = ST_IDLE;
          w_clr  = 1'b1;
        end else if (start && door_closed) begin
          w_next = ST_COOK;
        end
      end
      ST_DONE: begin
        if (load_en) begin
          w_load = 1'b1;
          w_next = ST_IDLE;
        end else if (start || stop) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Reset holds the latch-clear pulse high so the magnetron is forced off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_set     <= 1'b0;
      r_reset   <= 1'b1;
      r_cooking <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_set     <= (w_next == ST_COOK) && (r_state != ST_COOK);
      r_reset   <= (r_state == ST_COOK) && (w_next != ST_COOK);
      r_cooking <= (w_next == ST_COOK);
      r_done    <= w_done;
    end
  end

  assign set       = r_set;
  assign reset     = r_reset;
  assign cooking   = r_cooking;
  assign done      = r_done;
  assign remaining = w_remaining;

endmodule
`default_nettype wire

// File: tb/tb_mag_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mag_ctrl : scoreboard bench for mag_ctrl with a reference model   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_mag_ctrl;

  localparam int c_max = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       load_en = 1'b0;
  logic [6:0] load_secs = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic       set;
  logic       reset;
  logic       cooking;
  logic [6:0] remaining;
  logic       done;

  always #5 clk = ~clk;

  mag_ctrl #(
    .MAX_SECS (99),
    .TIME_W   (7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .load_en     (load_en),
    .load_secs   (load_secs),
    .start       (start),
    .stop        (stop),
    .door_closed (door_closed),
    .set         (set),
    .reset       (reset),
    .cooking     (cooking),
    .remaining   (remaining),
    .done        (done)
  );

  typedef struct packed {
    logic       set;
    logic       rst_p;
    logic       cook;
    logic       done;
    logic [6:0] rem;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference oven: mode names are the bench's own, secs is plain integer time.
  localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode = M_IDLE;
  int m_secs = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > c_max) ? c_max : v;
  endfunction

  function automatic exp_t model_step(input bit rn, input bit t, input bit ld,
                                      input int ls, input bit st, input bit sp,
                                      input bit dc);
    exp_t e;
    bit   was_cook;
    bit   expired;
    e = '0;
    if (!rn) begin
      m_mode  = M_IDLE;
      m_secs  = 0;
      e.rst_p = 1'b1;
      return e;
    end
    was_cook = (m_mode == M_COOK);
    expired  = 1'b0;
    if (m_mode == M_IDLE) begin
      if (ld) m_secs = clamp(ls);
      else if (st && dc && m_secs > 0) m_mode = M_COOK;
    end else if (m_mode == M_COOK) begin
      if (!dc || sp) m_mode = M_PAUSE;
      else if (t) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode  = M_DONE;
          expired = 1'b1;
        end
      end
    end else if (m_mode == M_PAUSE) begin
      if (sp) begin
        m_mode = M_IDLE;
        m_secs = 0;
      end else if (st && dc) m_mode = M_COOK;
    end else begin
      if (ld) begin
        m_secs = clamp(ls);
        m_mode = M_IDLE;
      end else if (st || sp) m_mode = M_IDLE;
    end
    e.cook  = (m_mode == M_COOK);
    e.set   = e.cook && !was_cook;
    e.rst_p = was_cook && !e.cook;
    e.done  = expired;
    e.rem   = 7'(m_secs);
    return e;
  endfunction

  // Inputs change just after the falling edge; the model is advanced at the rising edge.
  task automatic step(input bit rn, input bit t, input bit ld, input logic [6:0] ls,
                      input bit st, input bit sp, input bit dc);
    @(negedge clk);
    #1;
    rst_n       = rn;
    tick_1hz    = t;
    load_en     = ld;
    load_secs   = ls;
    start       = st;
    stop        = sp;
    door_closed = dc;
    @(posedge clk);
    sb.push_back(model_step(rn, t, ld, int'(ls), st, sp, dc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 7'd0, 0, 0, 1);
  endtask

  logic win = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("set", int'(set), int'(e.set));
      check("reset", int'(reset), int'(e.rst_p));
      check("cooking", int'(cooking), int'(e.cook));
      check("done", int'(done), int'(e.done));
      check("remaining", int'(remaining), int'(e.rem));
      check("set_reset_excl", int'(set && reset), 0);
      if (set) win = 1'b1;
      else if (reset) win = 1'b0;
      check("cook_window", int'(cooking), int'(win));
    end
  end

  initial begin
    // Reset held, then released
    step(0, 0, 0, 7'd0, 0, 0, 1);
    step(0, 1, 1, 7'd9, 1, 0, 1);
    idle(2);

    // Load 3, run to expiry
    step(1, 0, 1, 7'd3, 0, 0, 1);
    step(1, 0, 0, 7'd0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 7'd0, 0, 0, 1);
    step(1, 1, 0, 7'd0, 0, 0, 1);
    idle(1);

    // Load 5 from DONE, door opens on a tick, then resume
    step(1, 0, 1, 7'd5, 0, 0, 1);
    step(1, 0, 0, 7'd0, 1, 0, 1);
    step(1, 1, 0, 7'd0, 0, 0, 1);
    step(1, 1, 0, 7'd0, 0, 0, 1);
    step(1, 1, 0, 7'd0, 0, 0, 0);
    step(1, 1, 0, 7'd0, 1, 0, 0);
    step(1, 0, 0, 7'd0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 7'd0, 0, 0, 1);
    step(1, 0, 0, 7'd0, 0, 1, 1);

    // Saturating load, start with nothing loaded, load+start together
    step(1, 0, 0, 7'd0, 1, 0, 1);
    step(1, 0, 1, 7'd120, 0, 0, 1);
    step(1, 0, 1, 7'd0, 0, 0, 1);
    step(1, 0, 0, 7'd0, 1, 0, 1);
    step(1, 0, 1, 7'd4, 1, 0, 1);

    // Pause with stop and start together
    step(1, 0, 0, 7'd0, 1, 0, 1);
    step(1, 1, 0, 7'd0, 0, 0, 1);
    step(1, 1, 0, 7'd0, 0, 1, 1);
    step(1, 0, 0, 7'd0, 1, 1, 1);
    idle(1);

    // Reset mid-cook
    step(1, 0, 1, 7'd6, 0, 0, 1);
    step(1, 0, 0, 7'd0, 1, 0, 1);
    step(1, 1, 0, 7'd0, 0, 0, 1);
    step(0, 0, 0, 7'd0, 1, 0, 1);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(99) != 0,
           $urandom_range(9) < 4,
           $urandom_range(11) == 0,
           7'($urandom_range(127)),
           $urandom_range(4) == 0,
           $urandom_range(13) == 0,
           $urandom_range(9) != 0);
    end

    idle(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
